// File: rtl/op_pkg.sv
// rtl/op_pkg.sv - shared types and line-geometry helpers for the L1I fetch arbiter
package op_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_arb_state_e;

  localparam int unsigned DEF_CACHE_LINE_WIDTH = 64;
  localparam int unsigned DEF_LINE_OFF         = $clog2(DEF_CACHE_LINE_WIDTH);

  // Number of byte-offset bits inside a cache line of the given size.
  function automatic int unsigned line_off_bits(input int unsigned line_bytes);
    return $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/l1i_nlp_gen.sv
// rtl/l1i_nlp_gen.sv - next-line prefetch candidate register with demand dedupe
module l1i_nlp_gen #(
  parameter int unsigned PC_WIDTH         = 64,
  parameter int unsigned CACHE_LINE_WIDTH = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                set_i,
  input  logic [PC_WIDTH-1:0] set_line_i,
  input  logic                issue_i,
  input  logic                accept_i,
  input  logic [PC_WIDTH-1:0] accept_line_i,
  output logic                pf_pending_o,
  output logic [PC_WIDTH-1:0] pf_addr_o
);
  import op_pkg::*;

  logic                pf_pending_q, pf_pending_d;
  logic [PC_WIDTH-1:0] pf_addr_q, pf_addr_d;

  // Flush wins; a new demand delivery replaces any older candidate; issue or a
  // matching demand consumes it. Set and accept never coincide (WAIT vs IDLE).
  always_comb begin
    pf_pending_d = pf_pending_q;
    pf_addr_d    = pf_addr_q;
    if (flush_i) begin
      pf_pending_d = 1'b0;
    end else if (set_i) begin
      pf_pending_d = 1'b1;
      pf_addr_d    = set_line_i + PC_WIDTH'(CACHE_LINE_WIDTH);
    end else if (issue_i || (accept_i && (accept_line_i == pf_addr_q))) begin
      pf_pending_d = 1'b0;
    end
  end

  // Candidate registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pf_pending_q <= 1'b0;
      pf_addr_q    <= '0;
    end else begin
      pf_pending_q <= pf_pending_d;
      pf_addr_q    <= pf_addr_d;
    end
  end

  assign pf_pending_o = pf_pending_q;
  assign pf_addr_o    = pf_addr_q;

endmodule

// File: rtl/l1i_fetch_arbiter.sv
// rtl/l1i_fetch_arbiter.sv - single-outstanding L1I request sequencer; L1I_NLP_EN adds next-line prefetch
module l1i_fetch_arbiter #(
  parameter int unsigned CACHE_LINE_WIDTH = 64,
  parameter int unsigned PC_WIDTH         = 64,
  parameter int unsigned DROP_CNT_WIDTH   = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_N_in,
  input  logic                          bp_req_valid,
  input  logic [PC_WIDTH-1:0]           bp_req_addr,
  output logic                          bp_req_ready,
  input  logic                          flush_in,
  output logic                          l1i_req_valid,
  output logic [PC_WIDTH-1:0]           l1i_req_addr,
  input  logic                          l1i_ready,
  input  logic                          l1i_valid,
  input  logic [CACHE_LINE_WIDTH*8-1:0] l1i_cacheline,
  output logic                          resp_valid,
  output logic                          resp_demand,
  output logic [PC_WIDTH-1:0]           resp_addr,
  output logic [CACHE_LINE_WIDTH*8-1:0] resp_cacheline,
  output logic [DROP_CNT_WIDTH-1:0]     drop_count
);
  import op_pkg::*;

  localparam int unsigned LINE_OFF = line_off_bits(CACHE_LINE_WIDTH);
  localparam int unsigned LINE_W   = CACHE_LINE_WIDTH * 8;
  localparam logic [PC_WIDTH-1:0] LINE_MASK = {{(PC_WIDTH-LINE_OFF){1'b1}}, {LINE_OFF{1'b0}}};

  fetch_arb_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0]       req_addr_q, req_addr_d;
  logic                      req_demand_q, req_demand_d;
  logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;
  logic                      resp_valid_q, resp_valid_d;
  logic                      resp_demand_q, resp_demand_d;
  logic [PC_WIDTH-1:0]       resp_addr_q, resp_addr_d;
  logic [LINE_W-1:0]         resp_cacheline_q, resp_cacheline_d;

  logic                resp_load;
  logic                drop_hit;
  logic                pf_pending;
  logic [PC_WIDTH-1:0] pf_addr;
  logic [PC_WIDTH-1:0] bp_line;

  assign bp_line = bp_req_addr & LINE_MASK;

  // Gated by reset so every output reads 0 while reset is held.
  assign bp_req_ready = rst_N_in & (state_q == IDLE) & ~flush_in;

  // Next-state logic: demand beats prefetch in IDLE; a flush after the request
  // handshake must still swallow the matching response, hence DROP.
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    req_demand_d = req_demand_q;
    resp_load    = 1'b0;
    drop_hit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush_in) begin
          if (bp_req_valid) begin
            req_addr_d   = bp_line;
            req_demand_d = 1'b1;
            state_d      = REQ;
          end else if (pf_pending) begin
            req_addr_d   = pf_addr;
            req_demand_d = 1'b0;
            state_d      = REQ;
          end
        end
      end
      REQ: begin
        if (l1i_ready) begin
          state_d = flush_in ? DROP : WAIT;
        end else if (flush_in) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (l1i_valid) begin
          state_d = IDLE;
          if (flush_in) begin
            drop_hit = 1'b1;
          end else begin
            resp_load = 1'b1;
          end
        end else if (flush_in) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (l1i_valid) begin
          state_d  = IDLE;
          drop_hit = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response capture and saturating stale-drop counter.
  always_comb begin
    resp_valid_d     = resp_load;
    resp_demand_d    = resp_load ? req_demand_q : resp_demand_q;
    resp_addr_d      = resp_load ? req_addr_q : resp_addr_q;
    resp_cacheline_d = resp_load ? l1i_cacheline : resp_cacheline_q;
    drop_count_d     = drop_count_q;
    if (drop_hit && (drop_count_q != {DROP_CNT_WIDTH{1'b1}})) begin
      drop_count_d = drop_count_q + DROP_CNT_WIDTH'(1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_q          <= IDLE;
      req_addr_q       <= '0;
      req_demand_q     <= 1'b0;
      drop_count_q     <= '0;
      resp_valid_q     <= 1'b0;
      resp_demand_q    <= 1'b0;
      resp_addr_q      <= '0;
      resp_cacheline_q <= '0;
    end else begin
      state_q          <= state_d;
      req_addr_q       <= req_addr_d;
      req_demand_q     <= req_demand_d;
      drop_count_q     <= drop_count_d;
      resp_valid_q     <= resp_valid_d;
      resp_demand_q    <= resp_demand_d;
      resp_addr_q      <= resp_addr_d;
      resp_cacheline_q <= resp_cacheline_d;
    end
  end

`ifdef L1I_NLP_EN
  logic pf_set;
  logic pf_issue;
  logic pf_accept;

  assign pf_set    = resp_load & req_demand_q;
  assign pf_issue  = (state_q == IDLE) & ~flush_in & ~bp_req_valid;
  assign pf_accept = bp_req_valid & bp_req_ready;

  l1i_nlp_gen #(
    .PC_WIDTH         (PC_WIDTH),
    .CACHE_LINE_WIDTH (CACHE_LINE_WIDTH)
  ) u_nlp (
    .clk_i         (clk_in),
    .rst_ni        (rst_N_in),
    .flush_i       (flush_in),
    .set_i         (pf_set),
    .set_line_i    (req_addr_q),
    .issue_i       (pf_issue),
    .accept_i      (pf_accept),
    .accept_line_i (bp_line),
    .pf_pending_o  (pf_pending),
    .pf_addr_o     (pf_addr)
  );
`else
  assign pf_pending = 1'b0;
  assign pf_addr    = '0;
`endif

  assign l1i_req_valid  = (state_q == REQ);
  assign l1i_req_addr   = req_addr_q;
  assign resp_valid     = resp_valid_q;
  assign resp_demand    = resp_demand_q;
  assign resp_addr      = resp_addr_q;
  assign resp_cacheline = resp_cacheline_q;
  assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_l1i_fetch_arbiter.sv
// tb/tb_l1i_fetch_arbiter.sv - directed self-checking bench for l1i_fetch_arbiter
module tb_l1i_fetch_arbiter;
  localparam int unsigned PCW = 64;
  localparam int unsigned CLW = 64;
  localparam int unsigned DCW = 2;
  localparam int unsigned LW  = CLW * 8;

  logic           clk_in = 1'b0;
  logic           rst_N_in = 1'b0;
  logic           bp_req_valid = 1'b0;
  logic [PCW-1:0] bp_req_addr = '0;
  logic           bp_req_ready;
  logic           flush_in = 1'b0;
  logic           l1i_req_valid;
  logic [PCW-1:0] l1i_req_addr;
  logic           l1i_ready = 1'b0;
  logic           l1i_valid = 1'b0;
  logic [LW-1:0]  l1i_cacheline = '0;
  logic           resp_valid;
  logic           resp_demand;
  logic [PCW-1:0] resp_addr;
  logic [LW-1:0]  resp_cacheline;
  logic [DCW-1:0] drop_count;

  int vec  = 0;
  int miss = 0;

  l1i_fetch_arbiter #(
    .CACHE_LINE_WIDTH (CLW),
    .PC_WIDTH         (PCW),
    .DROP_CNT_WIDTH   (DCW)
  ) dut (
    .clk_in         (clk_in),
    .rst_N_in       (rst_N_in),
    .bp_req_valid   (bp_req_valid),
    .bp_req_addr    (bp_req_addr),
    .bp_req_ready   (bp_req_ready),
    .flush_in       (flush_in),
    .l1i_req_valid  (l1i_req_valid),
    .l1i_req_addr   (l1i_req_addr),
    .l1i_ready      (l1i_ready),
    .l1i_valid      (l1i_valid),
    .l1i_cacheline  (l1i_cacheline),
    .resp_valid     (resp_valid),
    .resp_demand    (resp_demand),
    .resp_addr      (resp_addr),
    .resp_cacheline (resp_cacheline),
    .drop_count     (drop_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    #2;
    vec++; if (bp_req_ready !== 1'b0) begin miss++; $display("FAIL rst_ready got %0h exp 0", bp_req_ready); end
    vec++; if (l1i_req_valid !== 1'b0) begin miss++; $display("FAIL rst_req_valid got %0h exp 0", l1i_req_valid); end
    vec++; if (l1i_req_addr !== '0) begin miss++; $display("FAIL rst_req_addr got %0h exp 0", l1i_req_addr); end
    vec++; if ({resp_valid, resp_demand} !== 2'b00) begin miss++; $display("FAIL rst_resp_flags got %0h exp 0", {resp_valid, resp_demand}); end
    vec++; if (resp_addr !== '0) begin miss++; $display("FAIL rst_resp_addr got %0h exp 0", resp_addr); end
    vec++; if (resp_cacheline !== '0) begin miss++; $display("FAIL rst_resp_line got %0h exp 0", resp_cacheline); end
    vec++; if (drop_count !== '0) begin miss++; $display("FAIL rst_drop got %0h exp 0", drop_count); end
    tick();
    tick();
    rst_N_in = 1'b1;
    #1;
    vec++; if (bp_req_ready !== 1'b1) begin miss++; $display("FAIL rst_release_ready got %0h exp 1", bp_req_ready); end
  endtask

  task automatic test_basic_demand();
    logic [LW-1:0] line_a;
    line_a = {8{64'hA5A5_0000_1234_5678}};
    bp_req_valid = 1'b1; bp_req_addr = 64'h1234;
    #1;
    vec++; if (bp_req_ready !== 1'b1) begin miss++; $display("FAIL basic_ready_T got %0h exp 1", bp_req_ready); end
    tick(); bp_req_valid = 1'b0; bp_req_addr = '0; l1i_ready = 1'b1; #1;
    vec++; if (l1i_req_valid !== 1'b1) begin miss++; $display("FAIL basic_req_valid got %0h exp 1", l1i_req_valid); end
    vec++; if (l1i_req_addr !== 64'h1200) begin miss++; $display("FAIL basic_req_addr got %0h exp 1200", l1i_req_addr); end
    vec++; if (bp_req_ready !== 1'b0) begin miss++; $display("FAIL basic_ready_busy got %0h exp 0", bp_req_ready); end
    tick(); l1i_ready = 1'b0; #1;
    vec++; if (l1i_req_valid !== 1'b0) begin miss++; $display("FAIL basic_req_drop got %0h exp 0", l1i_req_valid); end
    tick();
    tick(); l1i_valid = 1'b1; l1i_cacheline = line_a; #1;
    tick(); l1i_valid = 1'b0; l1i_cacheline = '0; #1;
    vec++; if (resp_valid !== 1'b1) begin miss++; $display("FAIL basic_resp_valid got %0h exp 1", resp_valid); end
    vec++; if (resp_demand !== 1'b1) begin miss++; $display("FAIL basic_resp_demand got %0h exp 1", resp_demand); end
    vec++; if (resp_addr !== 64'h1200) begin miss++; $display("FAIL basic_resp_addr got %0h exp 1200", resp_addr); end
    vec++; if (resp_cacheline !== line_a) begin miss++; $display("FAIL basic_resp_line got %0h exp %0h", resp_cacheline, line_a); end
    vec++; if (bp_req_ready !== 1'b1) begin miss++; $display("FAIL basic_ready_after got %0h exp 1", bp_req_ready); end
    flush_in = 1'b1; #1;
    vec++; if (bp_req_ready !== 1'b0) begin miss++; $display("FAIL basic_ready_flush got %0h exp 0", bp_req_ready); end
    tick(); flush_in = 1'b0; #1;
    vec++; if (resp_valid !== 1'b0) begin miss++; $display("FAIL basic_resp_pulse got %0h exp 0", resp_valid); end
    vec++; if (l1i_req_valid !== 1'b0) begin miss++; $display("FAIL basic_no_req got %0h exp 0", l1i_req_valid); end
  endtask

  task automatic test_flush_wait();
    bp_req_valid = 1'b1; bp_req_addr = 64'h4000; #1;
    tick(); bp_req_valid = 1'b0; l1i_ready = 1'b1; #1;
    vec++; if (l1i_req_addr !== 64'h4000) begin miss++; $display("FAIL fw_req_addr got %0h exp 4000", l1i_req_addr); end
    tick(); l1i_ready = 1'b0; flush_in = 1'b1; #1;
    tick(); flush_in = 1'b0; #1;
    vec++; if (bp_req_ready !== 1'b0) begin miss++; $display("FAIL fw_ready_drop got %0h exp 0", bp_req_ready); end
    tick();
    tick(); l1i_valid = 1'b1; #1;
    vec++; if (drop_count !== 2'd0) begin miss++; $display("FAIL fw_drop_before got %0h exp 0", drop_count); end
    tick(); l1i_valid = 1'b0; #1;
    vec++; if (resp_valid !== 1'b0) begin miss++; $display("FAIL fw_no_resp got %0h exp 0", resp_valid); end
    vec++; if (drop_count !== 2'd1) begin miss++; $display("FAIL fw_drop_after got %0h exp 1", drop_count); end
    vec++; if (bp_req_ready !== 1'b1) begin miss++; $display("FAIL fw_ready_idle got %0h exp 1", bp_req_ready); end
  endtask

  task automatic test_flush_req();
    bp_req_valid = 1'b1; bp_req_addr = 64'h5000; #1;
    tick(); bp_req_valid = 1'b0; l1i_ready = 1'b0; #1;
    vec++; if (l1i_req_valid !== 1'b1) begin miss++; $display("FAIL fr_req_valid got %0h exp 1", l1i_req_valid); end
    flush_in = 1'b1; #1;
    tick(); flush_in = 1'b0; #1;
    vec++; if (l1i_req_valid !== 1'b0) begin miss++; $display("FAIL fr_withdrawn got %0h exp 0", l1i_req_valid); end
    vec++; if (bp_req_ready !== 1'b1) begin miss++; $display("FAIL fr_ready_idle got %0h exp 1", bp_req_ready); end
    vec++; if (drop_count !== 2'd1) begin miss++; $display("FAIL fr_drop_same got %0h exp 1", drop_count); end
    l1i_valid = 1'b1; #1;
    tick(); l1i_valid = 1'b0; #1;
    vec++; if (resp_valid !== 1'b0) begin miss++; $display("FAIL fr_stray_resp got %0h exp 0", resp_valid); end
    vec++; if (drop_count !== 2'd1) begin miss++; $display("FAIL fr_stray_drop got %0h exp 1", drop_count); end
  endtask

  task automatic test_flush_with_valid();
    bp_req_valid = 1'b1; bp_req_addr = 64'h6000; #1;
    tick(); bp_req_valid = 1'b0; l1i_ready = 1'b1; #1;
    tick(); l1i_ready = 1'b0; #1;
    tick(); l1i_valid = 1'b1; flush_in = 1'b1; #1;
    tick(); l1i_valid = 1'b0; flush_in = 1'b0; #1;
    vec++; if (resp_valid !== 1'b0) begin miss++; $display("FAIL fv_no_resp got %0h exp 0", resp_valid); end
    vec++; if (drop_count !== 2'd2) begin miss++; $display("FAIL fv_drop got %0h exp 2", drop_count); end
    vec++; if (bp_req_ready !== 1'b1) begin miss++; $display("FAIL fv_ready_idle got %0h exp 1", bp_req_ready); end
  endtask

  task automatic test_reset_mid_wait();
    bp_req_valid = 1'b1; bp_req_addr = 64'h8000; #1;
    tick(); bp_req_valid = 1'b0; l1i_ready = 1'b1; #1;
    tick(); l1i_ready = 1'b0; #1;
    rst_N_in = 1'b0; #1;
    vec++; if (drop_count !== '0) begin miss++; $display("FAIL rw_drop got %0h exp 0", drop_count); end
    vec++; if (resp_addr !== '0) begin miss++; $display("FAIL rw_resp_addr got %0h exp 0", resp_addr); end
    vec++; if (resp_cacheline !== '0) begin miss++; $display("FAIL rw_resp_line got %0h exp 0", resp_cacheline); end
    vec++; if (resp_demand !== 1'b0) begin miss++; $display("FAIL rw_resp_demand got %0h exp 0", resp_demand); end
    vec++; if (l1i_req_addr !== '0) begin miss++; $display("FAIL rw_req_addr got %0h exp 0", l1i_req_addr); end
    vec++; if ({bp_req_ready, l1i_req_valid, resp_valid} !== 3'b000) begin miss++; $display("FAIL rw_flags got %0h exp 0", {bp_req_ready, l1i_req_valid, resp_valid}); end
    tick(); rst_N_in = 1'b1; #1;
    vec++; if (bp_req_ready !== 1'b1) begin miss++; $display("FAIL rw_ready_idle got %0h exp 1", bp_req_ready); end
    l1i_valid = 1'b1; #1;
    tick(); l1i_valid = 1'b0; #1;
    vec++; if (resp_valid !== 1'b0) begin miss++; $display("FAIL rw_late_resp got %0h exp 0", resp_valid); end
    vec++; if (drop_count !== '0) begin miss++; $display("FAIL rw_late_drop got %0h exp 0", drop_count); end
  endtask

  task automatic test_drop_saturate();
    logic [DCW-1:0] exp_drop;
    for (int i = 0; i < 4; i++) begin
      exp_drop = (i >= 2) ? 2'd3 : DCW'(i + 1);
      bp_req_valid = 1'b1; bp_req_addr = 64'h9000 + 64'(i * 64); #1;
      tick(); bp_req_valid = 1'b0; l1i_ready = 1'b1; flush_in = 1'b1; #1;
      tick(); l1i_ready = 1'b0; #1;
      tick(); flush_in = 1'b0; #1;
      vec++; if (bp_req_ready !== 1'b0) begin miss++; $display("FAIL sat_still_drop[%0d] got %0h exp 0", i, bp_req_ready); end
      l1i_valid = 1'b1; #1;
      tick(); l1i_valid = 1'b0; #1;
      vec++; if (resp_valid !== 1'b0) begin miss++; $display("FAIL sat_no_resp[%0d] got %0h exp 0", i, resp_valid); end
      vec++; if (drop_count !== exp_drop) begin miss++; $display("FAIL sat_drop[%0d] got %0h exp %0h", i, drop_count, exp_drop); end
    end
  endtask

  task automatic test_back_to_back();
    bp_req_valid = 1'b1; bp_req_addr = 64'h1000; #1;
    tick(); bp_req_valid = 1'b0; l1i_ready = 1'b1; #1;
    tick(); l1i_ready = 1'b0; #1;
    tick(); l1i_valid = 1'b1; l1i_cacheline = {16{32'h0000_1000}}; #1;
    tick(); l1i_valid = 1'b0; bp_req_valid = 1'b1; bp_req_addr = 64'h1040; #1;
    vec++; if (resp_addr !== 64'h1000) begin miss++; $display("FAIL b2b_resp0_addr got %0h exp 1000", resp_addr); end
    vec++; if (bp_req_ready !== 1'b1) begin miss++; $display("FAIL b2b_ready got %0h exp 1", bp_req_ready); end
    tick(); bp_req_valid = 1'b0; l1i_ready = 1'b1; #1;
    vec++; if (l1i_req_addr !== 64'h1040) begin miss++; $display("FAIL b2b_req1_addr got %0h exp 1040", l1i_req_addr); end
    vec++; if (resp_valid !== 1'b0) begin miss++; $display("FAIL b2b_resp_pulse got %0h exp 0", resp_valid); end
    tick(); l1i_ready = 1'b0; #1;
    tick(); l1i_valid = 1'b1; #1;
    tick(); l1i_valid = 1'b0; #1;
    vec++; if ({resp_valid, resp_demand} !== 2'b11) begin miss++; $display("FAIL b2b_resp1_flags got %0h exp 3", {resp_valid, resp_demand}); end
    vec++; if (resp_addr !== 64'h1040) begin miss++; $display("FAIL b2b_resp1_addr got %0h exp 1040", resp_addr); end
    tick();
`ifdef L1I_NLP_EN
    vec++; if ({l1i_req_valid, l1i_req_addr} !== {1'b1, 64'h1080}) begin miss++; $display("FAIL b2b_pf_req got %0h exp 1_1080", {l1i_req_valid, l1i_req_addr}); end
    l1i_ready = 1'b1; #1;
    tick(); l1i_ready = 1'b0; #1;
    tick(); l1i_valid = 1'b1; #1;
    tick(); l1i_valid = 1'b0; #1;
    vec++; if ({resp_valid, resp_demand} !== 2'b10) begin miss++; $display("FAIL b2b_pf_flags got %0h exp 2", {resp_valid, resp_demand}); end
    vec++; if (resp_addr !== 64'h1080) begin miss++; $display("FAIL b2b_pf_addr got %0h exp 1080", resp_addr); end
    tick(); tick();
    vec++; if (l1i_req_valid !== 1'b0) begin miss++; $display("FAIL b2b_pf_no_chain got %0h exp 0", l1i_req_valid); end
`else
    vec++; if (l1i_req_valid !== 1'b0) begin miss++; $display("FAIL b2b_no_pf got %0h exp 0", l1i_req_valid); end
`endif
  endtask

  task automatic test_top_line();
    bp_req_valid = 1'b1; bp_req_addr = 64'hFFFF_FFFF_FFFF_FFE5; #1;
    tick(); bp_req_valid = 1'b0; l1i_ready = 1'b1; #1;
    vec++; if (l1i_req_addr !== 64'hFFFF_FFFF_FFFF_FFC0) begin miss++; $display("FAIL top_req_addr got %0h exp ffffffffffffffc0", l1i_req_addr); end
    tick(); l1i_ready = 1'b0; #1;
    tick(); l1i_valid = 1'b1; #1;
    tick(); l1i_valid = 1'b0; #1;
    vec++; if ({resp_valid, resp_demand} !== 2'b11) begin miss++; $display("FAIL top_resp_flags got %0h exp 3", {resp_valid, resp_demand}); end
    tick(); #1;
`ifdef L1I_NLP_EN
    vec++; if ({l1i_req_valid, l1i_req_addr} !== {1'b1, 64'h0}) begin miss++; $display("FAIL top_pf_wrap got %0h exp 1_0", {l1i_req_valid, l1i_req_addr}); end
    l1i_ready = 1'b1; #1;
    tick(); l1i_ready = 1'b0; #1;
    tick(); l1i_valid = 1'b1; #1;
    tick(); l1i_valid = 1'b0; #1;
    vec++; if ({resp_valid, resp_demand, resp_addr} !== {2'b10, 64'h0}) begin miss++; $display("FAIL top_pf_resp got %0h exp 2_0", {resp_valid, resp_demand, resp_addr}); end
`else
    vec++; if (l1i_req_valid !== 1'b0) begin miss++; $display("FAIL top_no_pf got %0h exp 0", l1i_req_valid); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_demand();
    test_flush_wait();
    test_flush_req();
    test_flush_with_valid();
    test_reset_mid_wait();
    test_drop_saturate();
    test_back_to_back();
    test_top_line();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d vectors", vec);
    $fatal(1, "watchdog");
  end

endmodule
